fifo_drain_reader: RTL and testbench

//   Read-side master for the 32-bit two-bank SPRAM FIFO. Issues single-cycle

---
 rtl/fifo_drain_reader.sv | 131 +++++++++++++
 tb/tb_fifo_drain_reader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_reader.sv
// Read-side master for the two-bank SPRAM FIFO: credit-limited read pulses,
// response tracking, r_err back-off and a small local queue on a valid/ready stream.
module fifo_drain_reader #(
    parameter int unsigned DW        = 32,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned RSP_LAT   = 3,
    parameter int unsigned BACKOFF   = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             fifo_re,
    input  logic [DW-1:0]    fifo_do,
    input  logic             fifo_read_valid,
    input  logic             fifo_r_err,
    output logic [DW-1:0]    m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             empty_seen,
    output logic             proto_err,
    output logic [CNT_W-1:0] words_out
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned QW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SW = QW + 1;
    localparam int unsigned IW = $clog2(RSP_LAT + 2);
    localparam int unsigned BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_BACKOFF = 2'd2
    } state_t;

    state_t          state, next_state;
    logic [IW-1:0]   ign_cnt;
    logic [BW-1:0]   bo_cnt;
    logic [QW-1:0]   outstanding;
    logic [QW-1:0]   count;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [DW-1:0]   mem [BUF_DEPTH];

    logic            ign_active, rsp_any, rsp_ok, rsp_err_ok, push, pop, proto_hit;
    logic            credit_ok, re_next;
    logic [SW-1:0]   credit_sum;
    logic [QW-1:0]   cnt_after_pop, count_next;
    logic [PW-1:0]   rd_next;
    logic [DW-1:0]   head_next;

    // Response qualification: ignore window, unmatched responses, r_err priority
    always_comb begin
        ign_active = (ign_cnt != '0);
        rsp_any    = (fifo_read_valid | fifo_r_err) & ~ign_active;
        rsp_ok     = rsp_any & (outstanding != '0);
        rsp_err_ok = rsp_ok & fifo_r_err;
        push       = rsp_ok & fifo_read_valid & ~fifo_r_err;
        proto_hit  = rsp_any & ((outstanding == '0) | (fifo_read_valid & fifo_r_err));
        pop        = m_valid & m_ready;
        // fifo_re is still in flight this cycle, so it consumes a credit too
        credit_sum = SW'(count) + SW'(outstanding) + SW'(fifo_re);
        credit_ok  = (credit_sum < SW'(BUF_DEPTH));
    end

    // Next-state and read-issue decode
    always_comb begin
        next_state = state;
        re_next    = 1'b0;
        case (state)
            S_IDLE:    if (enable) next_state = S_ISSUE;
            S_ISSUE: begin
                if (rsp_err_ok)   next_state = S_BACKOFF;
                else if (!enable) next_state = S_IDLE;
                re_next = enable & credit_ok & ~ign_active & ~rsp_err_ok;
            end
            S_BACKOFF: if (bo_cnt == '0) next_state = enable ? S_ISSUE : S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Queue bookkeeping and the next head-of-queue word
    always_comb begin
        cnt_after_pop = count - QW'(pop);
        count_next    = cnt_after_pop + QW'(push);
        rd_next       = rd_ptr + PW'(pop);
        head_next     = m_data;
        if (push && (cnt_after_pop == '0)) head_next = fifo_do;
        else if (cnt_after_pop != '0)      head_next = mem[rd_next];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ign_cnt     <= IW'(RSP_LAT + 1);
            bo_cnt      <= '0;
            outstanding <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_re     <= 1'b0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            empty_seen  <= 1'b0;
            proto_err   <= 1'b0;
            words_out   <= '0;
        end else begin
            state      <= next_state;
            fifo_re    <= re_next;
            empty_seen <= (next_state == S_BACKOFF);
            if (ign_active) ign_cnt <= ign_cnt - IW'(1);
            if ((state != S_BACKOFF) && (next_state == S_BACKOFF)) bo_cnt <= BW'(BACKOFF - 1);
            else if ((state == S_BACKOFF) && (bo_cnt != '0))       bo_cnt <= bo_cnt - BW'(1);
            if (fifo_re && !rsp_ok)      outstanding <= outstanding + QW'(1);
            else if (!fifo_re && rsp_ok) outstanding <= outstanding - QW'(1);
            if (proto_hit) proto_err <= 1'b1;
            count   <= count_next;
            m_valid <= (count_next != '0);
            m_data  <= head_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_next;
            if (pop) words_out <= words_out + CNT_W'(1);
        end
    end

    // Queue storage carries no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fifo_do;
    end

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Directed bench for fifo_drain_reader: FIFO responder with 2-cycle latency,
// stream capture, and immediate-assertion checks at each step.
module tb_fifo_drain_reader;

    localparam int unsigned DW    = 32;
    localparam int unsigned BD    = 4;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             fifo_re;
    logic [DW-1:0]    fifo_do = '0;
    logic             fifo_read_valid = 1'b0;
    logic             fifo_r_err = 1'b0;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic             m_ready;
    logic             empty_seen;
    logic             proto_err;
    logic [CNT_W-1:0] words_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          v;
        logic          e;
        logic [DW-1:0] d;
    } rsp_t;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] got [$];
    rsp_t          p0 = '0;
    rsp_t          p1 = '0;
    logic          inj_v = 1'b0;
    logic [DW-1:0] inj_d = '0;
    int            reads = 0;
    int            rsps = 0;
    int            max_out = 0;
    bit            mon_on = 1'b0;

    always #5 clk = ~clk;

    fifo_drain_reader #(
        .DW(DW), .BUF_DEPTH(BD), .RSP_LAT(3), .BACKOFF(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_re(fifo_re),
        .fifo_do(fifo_do), .fifo_read_valid(fifo_read_valid), .fifo_r_err(fifo_r_err),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .empty_seen(empty_seen), .proto_err(proto_err), .words_out(words_out)
    );

    // FIFO responder (response two cycles after the read) plus stream monitor
    always @(negedge clk) begin
        if (!rst) begin
            reads = 0;
            rsps  = 0;
        end else begin
            if (fifo_re) reads++;
            if (fifo_read_valid || fifo_r_err) rsps++;
            if (mon_on && (reads - rsps) > max_out) max_out = reads - rsps;
            if (m_valid && m_ready) got.push_back(m_data);
        end
        fifo_read_valid = p1.v | inj_v;
        fifo_r_err      = p1.e;
        fifo_do         = inj_v ? inj_d : p1.d;
        p1 = p0;
        p0 = '0;
        if (fifo_re && rst) begin
            if (fifo_q.size() > 0) begin
                p0.v = 1'b1;
                p0.d = fifo_q.pop_front();
            end else begin
                p0.e = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hi;
        rst = 1'b0; enable = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_fifo_re",    64'(fifo_re), 64'd0);
        check("rst_m_valid",    64'(m_valid), 64'd0);
        check("rst_m_data",     64'(m_data), 64'd0);
        check("rst_words_out",  64'(words_out), 64'd0);
        check("rst_proto_err",  64'(proto_err), 64'd0);
        check("rst_empty_seen", 64'(empty_seen), 64'd0);

        // Streaming: ten words with downstream always ready
        drive_edge();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(32'h100 + i));
        mon_on = 1'b1; enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 300 && got.size() < 10; i++) @(negedge clk);
        check("t2_count", 64'(got.size()), 64'd10);
        for (int i = 0; i < 10 && i < got.size(); i++)
            check($sformatf("t2_word%0d", i), 64'(got[i]), 64'(32'h100 + i));
        @(negedge clk);
        check("t2_words_out", 64'(words_out), 64'd10);
        check("t2_max_out_le_depth", 64'(max_out <= int'(BD)), 64'd1);
        check("t2_proto_err", 64'(proto_err), 64'd0);
        mon_on = 1'b0;
        drive_edge();
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check("t2_drained", 64'(m_valid), 64'd0);

        // Backpressure: queue fills to BUF_DEPTH and head holds
        got.delete();
        base = reads;
        drive_edge();
        for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(32'h200 + i));
        m_ready = 1'b0; enable = 1'b1;
        repeat (20) @(negedge clk);
        check("t3_reads", 64'(reads - base), 64'(BD));
        check("t3_m_valid", 64'(m_valid), 64'd1);
        check("t3_head", 64'(m_data), 64'h200);
        check("t3_re_stopped", 64'(fifo_re), 64'd0);
        repeat (5) @(negedge clk);
        check("t3_head_stable", 64'(m_data), 64'h200);
        check("t3_reads_held", 64'(reads - base), 64'(BD));
        // Single pop from a full queue: exactly one new read refills it
        drive_edge();
        m_ready = 1'b1;
        drive_edge();
        m_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("t3_one_pop", 64'(got.size()), 64'd1);
        check("t3_next_head", 64'(m_data), 64'h201);
        check("t3_refill_read", 64'(reads - base), 64'(BD + 1));
        drive_edge();
        m_ready = 1'b1;
        for (int i = 0; i < 200 && got.size() < 6; i++) @(negedge clk);
        check("t3_count", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            check($sformatf("t3_word%0d", i), 64'(got[i]), 64'(32'h200 + i));
        drive_edge();
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check("t3_words_out", 64'(words_out), 64'd16);
        check("t3_proto_err", 64'(proto_err), 64'd0);

        // Empty FIFO: r_err, eight back-off cycles, then a retry
        drive_edge();
        enable = 1'b1;
        for (int i = 0; i < 40 && !empty_seen; i++) @(negedge clk);
        check("t4_backoff_entered", 64'(empty_seen), 64'd1);
        hi = 0;
        while (empty_seen && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        check("t4_backoff_len", 64'(hi), 64'd8);
        @(negedge clk);
        check("t4_retry", 64'(fifo_re), 64'd1);
        drive_edge();
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check("t4_proto_err", 64'(proto_err), 64'd0);

        // Unsolicited read_valid with nothing outstanding
        drive_edge();
        inj_d = 32'hDEAD_BEEF; inj_v = 1'b1;
        drive_edge();
        inj_v = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_proto_err", 64'(proto_err), 64'd1);
        check("t6_not_queued", 64'(m_valid), 64'd0);
        check("t6_words_out", 64'(words_out), 64'd16);
        repeat (10) @(negedge clk);
        check("t6_sticky", 64'(proto_err), 64'd1);

        // Reset with two reads in flight; late response lands in the ignore window
        drive_edge();
        for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(32'h300 + i));
        enable = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 20 && !fifo_re; i++) @(negedge clk);
        @(negedge clk);
        check("t1_second_read", 64'(fifo_re), 64'd1);
        drive_edge();
        rst = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("t1_rst_fifo_re",   64'(fifo_re), 64'd0);
        check("t1_rst_m_valid",   64'(m_valid), 64'd0);
        check("t1_rst_proto_err", 64'(proto_err), 64'd0);
        check("t1_rst_words_out", 64'(words_out), 64'd0);
        drive_edge();
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("t1_late_proto_err", 64'(proto_err), 64'd0);
        check("t1_late_m_valid",   64'(m_valid), 64'd0);
        check("t1_late_words_out", 64'(words_out), 64'd0);
        check("t1_idle_fifo_re",   64'(fifo_re), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
